// File: rtl/div_radix2.sv
// div_radix2: 32-bit radix-2 restoring divider (signed/unsigned); define DIV_EARLY_OUT_EN for the early-out path
module div_radix2 (
  input  logic        clk,
  input  logic        resetn,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);
  localparam logic [1:0] IDLE = 2'd0, DIVZERO = 2'd1, ON = 2'd2, END = 2'd3;
  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [64:0] acc;
  logic [31:0] dvs;
  logic        neg_q, neg_r;
  logic        a_neg, b_neg, early;
  logic [31:0] a_mag, b_mag, q_fin, r_fin;
  logic [65:0] shifted;
  logic [33:0] trial;
  logic [64:0] acc_n;
  // operand magnitudes, one restoring step and the sign-corrected final result
  always_comb begin
    a_neg   = signed_div_i & opdata1_i[31];
    b_neg   = signed_div_i & opdata2_i[31];
    a_mag   = a_neg ? 32'd0 - opdata1_i : opdata1_i;
    b_mag   = b_neg ? 32'd0 - opdata2_i : opdata2_i;
    shifted = {acc, 1'b0};
    trial   = shifted[65:32] - {2'b0, dvs};
    acc_n   = {trial[33] ? shifted[64:32] : trial[32:0], shifted[31:1], ~trial[33]};
    q_fin   = neg_q ? 32'd0 - acc_n[31:0] : acc_n[31:0];
    r_fin   = neg_r ? 32'd0 - acc_n[63:32] : acc_n[63:32];
`ifdef DIV_EARLY_OUT_EN
    early   = (b_mag != 32'd0) && (a_mag < b_mag);
`else
    early   = 1'b0;
`endif
  end
  // control FSM, iteration datapath and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      acc      <= 65'd0;
      dvs      <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= 64'h0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i && !annul_i) begin
          acc   <= {33'd0, a_mag};
          dvs   <= b_mag;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          cnt   <= 5'd0;
          if (b_mag == 32'd0) state <= DIVZERO;
          else if (early) begin
            state    <= END;
            ready_o  <= 1'b1;
            result_o <= {opdata1_i, 32'd0};
          end else state <= ON;
        end
        DIVZERO: if (annul_i) state <= IDLE;
        else begin
          state    <= END;
          ready_o  <= 1'b1;
          result_o <= 64'h0;
        end
        ON: if (annul_i) begin
          state <= IDLE;
          cnt   <= 5'd0;
        end else begin
          acc <= acc_n;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state    <= END;
            ready_o  <= 1'b1;
            result_o <= {r_fin, q_fin};
          end
        end
        END: if (!start_i) begin
          state    <= IDLE;
          ready_o  <= 1'b0;
          result_o <= 64'h0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_radix2.sv
// tb_div_radix2: scoreboard bench for div_radix2
module tb_div_radix2;
  logic        clk = 1'b0, resetn = 1'b0, signed_div = 1'b0, start = 1'b0, annul = 1'b0;
  logic [31:0] op1 = 32'd0, op2 = 32'd0;
  logic [63:0] result;
  logic        ready;
  int          checks = 0, errors = 0;
  logic [63:0] exp_q[$];
  int          lat_q[$];
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  always #5 clk = ~clk;

  div_radix2 dut (
    .clk(clk), .resetn(resetn), .signed_div_i(signed_div), .opdata1_i(op1), .opdata2_i(op2),
    .start_i(start), .annul_i(annul), .result_o(result), .ready_o(ready)
  );

  function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'h0;
    sa = sd ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sd ? longint'($signed(b)) : longint'({32'd0, b});
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int model_lat(input logic sd, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (sd && a[31]) ? 32'd0 - a : a;
    mb = (sd && b[31]) ? 32'd0 - b : b;
    if (b == 32'd0) return 2;
    if (EARLY && ma < mb) return 1;
    return 33;
  endfunction

  // Drives one request and holds start until ready; operands are scrambled after capture.
  task automatic issue(input logic sd, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [63:0] res);
    @(negedge clk);
    signed_div = sd; op1 = a; op2 = b; start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      op1 = $urandom; op2 = $urandom; signed_div = 1'($urandom_range(0, 1));
    end while (!ready && lat < 60);
    res = result;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
    resetn = 1'b1;
  endtask

  task automatic test_unsigned();
    int lat; logic [63:0] res, e; int el;
    exp_q.push_back({32'd2, 32'd14}); lat_q.push_back(33);
    issue(1'b0, 32'd100, 32'd7, lat, res);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (res !== e) begin errors++; $display("FAIL u100_7_result got %h exp %h", res, e); end
    checks++; if (lat !== el) begin errors++; $display("FAIL u100_7_latency got %0d exp %0d", lat, el); end
    start = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL u100_7_release_ready got %b exp 0", ready); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL u100_7_release_result got %h exp 0", result); end
  endtask

  task automatic test_signed();
    int lat; logic [63:0] res, e; int el;
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD}); lat_q.push_back(33);
    issue(1'b1, 32'hFFFFFFF9, 32'h2, lat, res);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (res !== e) begin errors++; $display("FAIL s_m7_2_result got %h exp %h", res, e); end
    checks++; if (lat !== el) begin errors++; $display("FAIL s_m7_2_latency got %0d exp %0d", lat, el); end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_overflow_hold();
    int lat; logic [63:0] res, e; int el;
    exp_q.push_back({32'h0, 32'h80000000}); lat_q.push_back(33);
    issue(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, res);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (res !== e) begin errors++; $display("FAIL ovf_result got %h exp %h", res, e); end
    checks++; if (lat !== el) begin errors++; $display("FAIL ovf_latency got %0d exp %0d", lat, el); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (ready !== 1'b1 || result !== e) begin
        errors++; $display("FAIL ovf_hold%0d got ready=%b %h exp ready=1 %h", i, ready, result, e);
      end
    end
    start = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ovf_release_ready got %b exp 0", ready); end
  endtask

  task automatic test_divzero();
    int lat; logic [63:0] res, e; int el;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(64'h0); lat_q.push_back(2);
      issue(1'(i), 32'hDEADBEEF, 32'd0, lat, res);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      checks++; if (res !== e) begin errors++; $display("FAIL divzero%0d_result got %h exp %h", i, res, e); end
      checks++; if (lat !== el) begin errors++; $display("FAIL divzero%0d_latency got %0d exp %0d", i, lat, el); end
      start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_annul();
    int lat; logic [63:0] res, e; int el; bit seen;
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    repeat (10) @(negedge clk);
    annul = 1'b1; start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    seen = 0;
    repeat (40) begin @(negedge clk); if (ready) seen = 1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL annul_on_ready got 1 exp 0"); end
    exp_q.push_back({32'd0, 32'd3}); lat_q.push_back(33);
    issue(1'b0, 32'd9, 32'd3, lat, res);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (res !== e) begin errors++; $display("FAIL after_annul_result got %h exp %h", res, e); end
    checks++; if (lat !== el) begin errors++; $display("FAIL after_annul_latency got %0d exp %0d", lat, el); end
    start = 1'b0;
    @(negedge clk);
    op1 = 32'd9; op2 = 32'd3; start = 1'b1; annul = 1'b1;
    seen = 0;
    repeat (40) begin @(negedge clk); if (ready) seen = 1; end
    start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL annul_idle_ready got 1 exp 0"); end
    op2 = 32'd0; start = 1'b1;
    @(negedge clk);
    annul = 1'b1; start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    seen = 0;
    repeat (5) begin @(negedge clk); if (ready) seen = 1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL annul_divzero_ready got 1 exp 0"); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [63:0] res, e; int el;
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    checks++; if (ready !== 1'b0 || result !== 64'h0) begin
      errors++; $display("FAIL reset_on got ready=%b %h exp ready=0 0", ready, result);
    end
    start = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    issue(1'b0, 32'd100, 32'd7, lat, res);
    #2 resetn = 1'b0; start = 1'b0;
    #1;
    checks++; if (ready !== 1'b0 || result !== 64'h0) begin
      errors++; $display("FAIL reset_end got ready=%b %h exp ready=0 0", ready, result);
    end
    @(negedge clk);
    resetn = 1'b1;
    exp_q.push_back({32'd2, 32'd14}); lat_q.push_back(33);
    issue(1'b0, 32'd100, 32'd7, lat, res);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (res !== e) begin errors++; $display("FAIL post_reset_result got %h exp %h", res, e); end
    checks++; if (lat !== el) begin errors++; $display("FAIL post_reset_latency got %0d exp %0d", lat, el); end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_early_out();
    int lat; logic [63:0] res, e; int el;
    exp_q.push_back({32'd5, 32'd0}); lat_q.push_back(EARLY ? 1 : 33);
    issue(1'b0, 32'd5, 32'd9, lat, res);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (res !== e) begin errors++; $display("FAIL early_5_9_result got %h exp %h", res, e); end
    checks++; if (lat !== el) begin errors++; $display("FAIL early_5_9_latency got %0d exp %0d", lat, el); end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic        sd[16];
    logic [31:0] a[16], b[16];
    int lat; logic [63:0] res, e; int el;
    for (int i = 0; i < 16; i++) begin
      sd[i] = 1'($urandom_range(0, 1));
      a[i]  = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 200);
      b[i]  = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : $urandom_range(1, 50));
      if (i == 0) begin a[i] = 32'h80000000; b[i] = 32'd3; sd[i] = 1'b1; end
      if (i == 1) begin a[i] = 32'hFFFFFFFF; b[i] = 32'd1; sd[i] = 1'b0; end
      exp_q.push_back(model(sd[i], a[i], b[i]));
      lat_q.push_back(model_lat(sd[i], a[i], b[i]));
    end
    for (int i = 0; i < 16; i++) begin
      issue(sd[i], a[i], b[i], lat, res);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      checks++; if (res !== e) begin
        errors++; $display("FAIL b2b%0d_result s=%b %h/%h got %h exp %h", i, sd[i], a[i], b[i], res, e);
      end
      checks++; if (lat !== el) begin errors++; $display("FAIL b2b%0d_latency got %0d exp %0d", i, lat, el); end
      start = 1'b0;
      @(negedge clk);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b%0d_release got %b exp 0", i, ready); end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow_hold();
    test_divzero();
    test_annul();
    test_reset_mid();
    test_early_out();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "watchdog");
  end
endmodule
